// File: rtl/irq_ctrl.sv
// Two-source interrupt controller: synchronises irq_in, records pending events,
// presents a stable irq_active code to the core and retires it on irq_ack.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  EDGE_MASK   = 2'b11,
  parameter int unsigned COOLDOWN    = 1
) (
  input  logic       clk,
  input  logic       a_reset_l,
  input  logic [1:0] irq_in,
  input  logic       cfg_w_en,
  input  logic [1:0] cfg_addr,
  input  logic [1:0] cfg_wdata,
  output logic [1:0] cfg_rdata,
  input  logic [1:0] irq_ack,
  output logic [1:0] irq_active,
  output logic [1:0] irq_pending
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_FORCE   = 2'd2;
  localparam int         CW           = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_COOL   = 2'd2
  } state_t;

  // The core sees source0 on bit 1 and source1 on bit 0.
  function automatic logic [1:0] swap2(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

  logic [1:0]    sync_q [SYNC_STAGES];
  logic [1:0]    s, s_d;
  logic [1:0]    pending_q, enable_q;
  logic [1:0]    set_ev, clr_ev, ack_acc, force_bits, w1c_bits;
  logic          wr_enable;
  state_t        state_q, state_d;
  logic [1:0]    snap_q, snap_d;
  logic [1:0]    snap_rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    active_d;

  // NOTE: the synchroniser array is reset too, so a stale high can't fake an edge after reset.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  assign wr_enable  = cfg_w_en && (cfg_addr == ADDR_ENABLE);
  assign w1c_bits   = (cfg_w_en && (cfg_addr == ADDR_PENDING)) ? cfg_wdata : 2'b00;
  assign force_bits = (cfg_w_en && (cfg_addr == ADDR_FORCE))   ? cfg_wdata : 2'b00;

  // Ack arrives in the active code's bit order; only bits inside snap are honoured.
  assign ack_acc = (state_q == S_ACTIVE) ? (swap2(irq_ack) & snap_q) : 2'b00;

  assign set_ev = (s & ~s_d & EDGE_MASK) | (s & ~EDGE_MASK) | force_bits;
  assign clr_ev = w1c_bits | ack_acc;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (set_ev[i])      pending_q[i] <= 1'b1;
        else if (clr_ev[i]) pending_q[i] <= 1'b0;
      end
      if (wr_enable) enable_q <= cfg_wdata;
    end
  end

  // State register; irq_active is a true flop so the core never sees decode glitches.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      cnt_q      <= '0;
      irq_active <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      irq_active <= active_d;
    end
  end

  assign snap_rem = snap_q & ~ack_acc;

  // NOTE: every output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if ((pending_q & enable_q) != 2'b00) begin
          snap_d  = pending_q & enable_q;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        snap_d = snap_rem;
        if (snap_rem == 2'b00) begin
          state_d = S_COOL;
          cnt_d   = '0;
        end
      end
      S_COOL: begin
        if (cnt_q == CW'(COOLDOWN - 1)) state_d = S_IDLE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        snap_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    active_d = 2'b00;
    if (state_d == S_ACTIVE) active_d = swap2(snap_d);
  end

  always_comb begin
    cfg_rdata = 2'b00;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = enable_q;
      ADDR_PENDING: cfg_rdata = pending_q;
      ADDR_FORCE:   cfg_rdata = (state_q == S_ACTIVE) ? swap2(snap_q) : 2'b00;
      default:      cfg_rdata = 2'b00;
    endcase
  end

  assign irq_pending = pending_q;

endmodule
